pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16; maximum consecutive MEM_WAIT cycles before error; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 16; width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Rs1_D, Rs2_D  input  5 each  source register numbers of the instruction in Decode.
REQ-006 RD_E  input  5  destination register of the instruction in Execute.
REQ-007 ResultSrcE0  input  1  high when the instruction in Execute is a load.
REQ-008 PCSrcE  input  1  high when the branch or jump in Execute is taken.
REQ-009 MemReqM  input  1  data-memory access active in Memory stage.
REQ-010 MemReadyM  input  1  data memory completes the access this cycle.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the stage pipeline register.
REQ-012 FlushD, FlushE, FlushW  output  1 each  clear the stage register to a bubble (all zeros).
REQ-013 mem_err  output  1  sticky memory-timeout flag.
REQ-014 lu_cnt, br_cnt, mw_cnt  output  CNT_W each  counts of load-use bubbles, branch flushes and memory-wait cycles.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, MEM_WAIT, ERR. The state SHALL be encoded in a registered state variable.
REQ-016 Define mem_stall as (MemReqM & ~MemReadyM) in RUN, or ~MemReadyM in MEM_WAIT.
REQ-017 On mem_stall, the block SHALL assert StallF, StallD, StallE, StallM and FlushW in the same cycle, combinationally. In that cycle it SHALL deassert FlushD, FlushE and the load-use outputs.
REQ-018 RUN -> MEM_WAIT SHALL occur when MemReqM=1 and MemReadyM=0. MEM_WAIT -> RUN SHALL occur on the cycle MemReadyM=1; in that cycle mem_stall=0 and there is no stall.
REQ-019 The timeout counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with MemReadyM=0. Reaching MEM_TIMEOUT SHALL cause MEM_WAIT -> ERR.
REQ-020 ERR SHALL be held until reset. In ERR: mem_err=1, all four Stall outputs=1, FlushW=1, and all other inputs are ignored.
REQ-021 Branch flush applies when PCSrcE=1 and mem_stall=0 in RUN. It SHALL assert FlushD=1 and FlushE=1 and leave all Stall outputs at 0.
REQ-022 Load-use applies when ResultSrcE0=1, RD_E!=0 and (RD_E==Rs1_D or RD_E==Rs2_D). It SHALL assert StallF=1, StallD=1 and FlushE=1, giving a one-cycle bubble.
REQ-023 Priority SHALL be mem_stall > branch flush > load-use. With a simultaneous branch and load-use, only the branch outputs SHALL assert.
REQ-024 lu_cnt, br_cnt and mw_cnt SHALL each increment by 1 per cycle in which their condition is the one acted on. All three SHALL saturate at all-ones and never wrap.
REQ-025 Hazard and flush outputs SHALL be combinational from state and inputs, with zero-cycle latency. Counters and mem_err SHALL update on the next edge.

Reset
REQ-026 While rst=1 the block SHALL hold: state=RUN, timeout counter=0, lu_cnt=br_cnt=mw_cnt=0, mem_err=0.
REQ-027 While rst=1 all Stall and Flush outputs SHALL be 0, regardless of other inputs.
REQ-028 Reset asserted mid-MEM_WAIT or in ERR SHALL return to RUN asynchronously. No pending wait SHALL be remembered after release.

Structure
REQ-029 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the x0 register constant 5'd0 SHALL live in the shared pipeline package.
REQ-030 The saturating counter SHALL be one sub-module, sat_counter (parameter W; ports clk, rst, inc, q), instantiated three times.

Verification
REQ-031 Rs1_D=5, RD_E=5, ResultSrcE0=1, other inputs 0 -> StallF=StallD=FlushE=1 for one cycle; lu_cnt 0->1.
REQ-032 RD_E=0, ResultSrcE0=1, Rs1_D=0 -> no stall, no flush; lu_cnt unchanged.
REQ-033 PCSrcE=1 together with the load-use condition of REQ-031 -> FlushD=FlushE=1 and StallF=StallD=0; br_cnt +1, lu_cnt unchanged.
REQ-034 MemReqM=1 and MemReadyM=0 for 3 cycles, then MemReadyM=1 -> four Stalls and FlushW high for exactly 3 cycles; mw_cnt=3; FSM back in RUN.
REQ-035 MEM_TIMEOUT=4, MemReadyM held at 0 -> ERR entered after 4 wait cycles; mem_err=1 and stays 1; rst pulse clears mem_err and returns to RUN.
REQ-036 CNT_W=4, 20 consecutive load-use cycles -> lu_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and architectural constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // Wait counter width covers the largest legal timeout (255)
  localparam int TO_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       Rs1_D;
  logic [4:0]       Rs2_D;
  logic [4:0]       RD_E;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mw_cnt;

  modport master (
    output Rs1_D, Rs2_D, RD_E, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  mem_err, lu_cnt, br_cnt, mw_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, RD_E, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output mem_err, lu_cnt, br_cnt, mw_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush, load-use bubble.
// Stall/flush outputs are combinational; counters and the error flag are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic            lu_hit;
  logic            mem_stall;
  logic            br_act;
  logic            lu_act;
  logic            err_hold;
  logic            hold_all;

  assign lu_hit = hz.ResultSrcE0 && (hz.RD_E != REG_X0) &&
                  ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    mem_stall = 1'b0;
    br_act    = 1'b0;
    lu_act    = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          to_cnt_d  = '0;
        end else if (hz.PCSrcE) begin
          br_act = 1'b1;
        end else if (lu_hit) begin
          lu_act = 1'b1;
        end
      end
      MEM_WAIT: begin
        // The release cycle is deliberately hazard-free: the pipeline just restarts
        if (!hz.MemReadyM) begin
          mem_stall = 1'b1;
          to_cnt_d  = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_LIM) begin
            state_d = ERR;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign mem_err_d = mem_err_q || (state_d == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign err_hold = (state_q == ERR);
  assign hold_all = mem_stall || err_hold;

  // Outputs are forced quiet while reset is asserted, whatever the inputs do
  assign hz.StallF  = !rst && (hold_all || lu_act);
  assign hz.StallD  = !rst && (hold_all || lu_act);
  assign hz.StallE  = !rst && hold_all;
  assign hz.StallM  = !rst && hold_all;
  assign hz.FlushW  = !rst && hold_all;
  assign hz.FlushD  = !rst && br_act;
  assign hz.FlushE  = !rst && (br_act || lu_act);
  assign hz.mem_err = mem_err_q;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu_act),
    .q   (hz.lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br_act),
    .q   (hz.br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_stall),
    .q   (hz.mw_cnt)
  );

endmodule
